// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard stall/flush controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // True when a non-$0 destination matches either source operand.
  function automatic logic reg_hit(input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] src_a,
                                   input logic [REG_W-1:0] src_b);
    return (rd != REG_ZERO) && ((rd == src_a) || (rd == src_b));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_watchdog.sv
// Memory-wait watchdog: saturating wait-cycle counter and sticky timeout flag.
module hazard_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);

  logic [TO_W-1:0] count;
  logic            at_limit;
  logic            hit_limit;

  assign at_limit  = (count == TO_W'(MEM_TIMEOUT));
  assign hit_limit = count_en && (count == TO_W'(MEM_TIMEOUT - 1));

  // Counter stops at MEM_TIMEOUT; the flag sets on the edge the counter gets there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      timeout <= 1'b0;
    end else begin
      if (clear)
        count <= '0;
      else if (count_en && !at_limit)
        count <= count + TO_W'(1);
      if (hit_limit)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, ID-branch operand,
// taken-branch squash and data-memory wait. Optional perf counter: HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             ID_Branch,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             IDEX_RegWrite,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] EXMEM_Rd,
  input  logic             EXMEM_MemRead,
  input  logic             BranchTaken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             PipeFreeze,
  output logic             MemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] StallCount
`endif
);

  state_t state, state_nxt;
  logic   lu, br_ex, br_mem, mem_stall;
  logic   wd_count, wd_clear;

  assign lu = IDEX_MemRead && (IDEX_Rd != REG_ZERO) &&
              ((IDEX_Rd == IFID_Rs) || (IFID_UsesRt && (IDEX_Rd == IFID_Rt)));
  assign br_ex     = ID_Branch && IDEX_RegWrite && reg_hit(IDEX_Rd, IFID_Rs, IFID_Rt);
  assign br_mem    = ID_Branch && EXMEM_MemRead && reg_hit(EXMEM_Rd, IFID_Rs, IFID_Rt);
  assign mem_stall = dmem_req && !dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state and pipeline controls; held at defaults while reset is asserted.
  always_comb begin
    state_nxt   = state;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    PipeFreeze  = 1'b0;
    wd_count    = 1'b0;
    wd_clear    = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            PipeFreeze = 1'b1;
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            wd_count   = 1'b1;
            state_nxt  = MEM_WAIT;
          end else if (BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
          end else if (br_ex && IDEX_MemRead) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            state_nxt   = HOLD;
          end else if (lu || br_ex || br_mem) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
          end
        end
        HOLD: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          if (mem_stall) begin
            PipeFreeze = 1'b1;
            wd_count   = 1'b1;
            state_nxt  = MEM_WAIT;
          end else begin
            IDEX_Bubble = 1'b1;
            state_nxt   = RUN;
          end
        end
        MEM_WAIT: begin
          // Hazard inputs are frozen here and get re-evaluated back in RUN.
          if (!dmem_ready) begin
            PipeFreeze = 1'b1;
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            wd_count   = 1'b1;
          end else begin
            wd_clear  = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  hazard_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (wd_count),
    .clear    (wd_clear),
    .timeout  (MemTimeout)
  );

`ifdef HAZARD_PERF_CNT_EN
  // Counts every cycle the PC is held (stall or freeze); wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      StallCount <= '0;
    else if (!PCWrite)
      StallCount <= StallCount + PERF_W'(1);
  end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline. It is the counterpart to the EX-stage forwarding unit and handles every hazard that forwarding cannot resolve: load-use, ID-stage branch operand dependencies, taken-branch squash and data-memory wait.
- Drives PC/IF-ID write enables, the ID/EX bubble mux and the flush lines.
- Holds an FSM for multi-cycle stalls and a memory-wait watchdog.

Parameters:
- MEM_TIMEOUT, 255: max consecutive dmem wait cycles before the sticky timeout flag sets.
- TO_W, 8: watchdog counter width; must satisfy MEM_TIMEOUT < 2^TO_W.
- PERF_W, 32: perf counter width (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- IFID_Rs  in  5  rs of instruction in ID.
- IFID_Rt  in  5  rt of instruction in ID.
- IFID_UsesRt  in  1  ID instruction reads rt.
- ID_Branch  in  1  ID instruction is beq/bne (compared in ID).
- IDEX_Rd  in  5  destination register in EX.
- IDEX_RegWrite  in  1  EX instruction writes a register.
- IDEX_MemRead  in  1  EX instruction is a load.
- EXMEM_Rd  in  5  destination register in MEM.
- EXMEM_MemRead  in  1  MEM instruction is a load.
- BranchTaken  in  1  branch resolved taken this cycle.
- dmem_req  in  1  MEM-stage access active.
- dmem_ready  in  1  data memory completes this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEX_Bubble  out  1  zero ID/EX control fields.
- IFID_Flush  out  1  clear IF/ID.
- PipeFreeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- MemTimeout  out  1  sticky watchdog error.
- StallCount  out  32  total stall cycles (optional feature only).

Behaviour:
- Matches (all require Rd != 0):
  - LU = IDEX_MemRead && IDEX_Rd==IFID_Rs, or IDEX_MemRead && IFID_UsesRt && IDEX_Rd==IFID_Rt.
  - BR_EX = ID_Branch && IDEX_RegWrite && IDEX_Rd in {IFID_Rs, IFID_Rt}.
  - BR_MEM = ID_Branch && EXMEM_MemRead && EXMEM_Rd in {IFID_Rs, IFID_Rt}.
- Stall outputs: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1.
- Freeze outputs: PipeFreeze=1, PCWrite=0, IFIDWrite=0, IDEX_Bubble=0.
- Defaults: PCWrite=1, IFIDWrite=1, all other outputs 0.
- All outputs are combinational from state and inputs. The state is registered.
- FSM states: RUN, HOLD, MEM_WAIT.
- RUN priority, highest first:
  1. dmem_req && !dmem_ready: freeze, go to MEM_WAIT, watchdog counter = 1.
  2. BranchTaken: IFID_Flush=1 and IDEX_Bubble=1, PCWrite=1, stay in RUN.
  3. BR_EX && IDEX_MemRead: stall, go to HOLD (exactly one extra stall cycle follows).
  4. LU or BR_EX or BR_MEM: stall for one cycle, stay in RUN.
- HOLD: stall unconditionally, then return to RUN. If dmem_req && !dmem_ready occurs in HOLD, freeze takes precedence and the FSM goes to MEM_WAIT. HOLD's remaining stall is dropped because the re-evaluation in RUN re-detects it.
- MEM_WAIT: freeze every cycle while !dmem_ready and increment the watchdog counter, saturating.
  - Counter reaching MEM_TIMEOUT sets MemTimeout, which stays set until reset.
  - dmem_ready: freeze ends in this cycle, with default outputs. The FSM returns to RUN and the counter clears.
  - BranchTaken and matches are ignored while frozen. Their inputs are held by the freeze and are re-evaluated in RUN.
- Net stall cycles:
  - load-use: 1.
  - branch on an ALU result in EX: 1.
  - branch on a load in EX: 2.
  - branch on a load in MEM: 1.
- Reset asserted at any time, including mid-HOLD or mid-MEM_WAIT: state=RUN, watchdog=0, MemTimeout=0, StallCount=0, outputs at defaults.
- Register $0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: StallCount port present. PERF_W-bit counter increments every cycle with PCWrite==0 (stall or freeze) and wraps modulo 2^PERF_W.
- Undefined: port and counter absent. All other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - FSM state typedef (RUN, HOLD, MEM_WAIT).
  - REG_ZERO constant (5'd0).
  - Reg address width constant (5).
- Sub-module hazard_watchdog: saturating wait counter plus the sticky MemTimeout flag. Inputs are clk, rst_n, count_en and clear.

Test Plan:
1. lw $2 in EX, ID add $3,$2,$4 -> one cycle with PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, then defaults.
2. lw $5 in EX, ID beq $5,$6 -> exactly two consecutive stall cycles (RUN then HOLD), then PCWrite=1.
3. lw $0 in EX, ID uses rs=0 -> no stall. IFID_UsesRt=0 with rt match -> no stall.
4. BranchTaken=1 in RUN with LU also true -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, no stall.
5. dmem_req=1, dmem_ready low for 3 cycles -> PipeFreeze=1 for those 3 cycles, with PCWrite=0, IFIDWrite=0, IDEX_Bubble=0. In the 4th cycle dmem_ready=1 -> PipeFreeze=0, defaults, FSM back to RUN. MEM_TIMEOUT=4 with ready never asserted -> MemTimeout=1 and stays set.
6. rst_n low during HOLD or MEM_WAIT -> outputs immediately at defaults, StallCount=0. With HAZARD_PERF_CNT_EN, scenario 2 yields StallCount=2.
